basic_gates_checker: RTL and testbench
======================================

# basic_gates_checker

Synthesizable self-checking response monitor for the `basic_gates` unit.
- Samples each applied `{a,b}` vector together with the seven observed gate outputs through a valid/ready handshake.
- Compares them against an internal golden model, counts vectors and mismatches, and tracks coverage of all four input combinations.
- Issues a single done/pass verdict.
- Complements the stimulus side: the driver applies vectors, and this block judges the responses in hardware for on-chip or FPGA self-test.

## Interface
Parameters:
- `NUM_VECTORS`, 4, number of vectors accepted per run (1 to 2^CNT_W−1)
- `CNT_W`, 8, width of vector and error counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `in_valid`  in  1  observation present on `a`, `b`, `obs`
- `in_ready`  out  1  checker accepts an observation this cycle
- `a`, `b`  in  1 each  applied stimulus bits
- `obs`  in  7  observed outputs: [6] and, [5] or, [4] not_a, [3] nand, [2] nor, [1] xor, [0] xnor
- `busy`  out  1  state is RUN
- `done`  out  1  state is DONE
- `pass`  out  1  valid while `done`: zero errors and full coverage
- `vec_count`  out  CNT_W  vectors accepted this run
- `err_count`  out  CNT_W  mismatching vectors, saturating
- `coverage`  out  4  bit `{a,b}` set once that combination was accepted
- `first_fail_vec`  out  CNT_W  index of the first mismatching vector
- `first_fail_mask`  out  7  `obs` XOR expected for the first mismatch; 0 if none

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on `start`.
  - All counters, `coverage` and the first-fail registers clear on that edge.
- RUN behaviour:
  - `in_ready`=1. An accept is `in_valid && in_ready`.
  - On each accept, `vec_count` increments and `coverage[{a,b}]` is set.
  - If `obs != exp({a,b})`, `err_count` increments (it saturates at all-ones).
  - On the first mismatch only, `first_fail_vec` ← the pre-increment `vec_count` and `first_fail_mask` ← `obs^exp`.
- Golden expected values: `{a,b}`=00 → 7'h1D, 01 → 7'h3A, 10 → 7'h2A, 11 → 7'h61.
- RUN → DONE on the edge accepting vector number `NUM_VECTORS`. The counters include that vector.
- DONE behaviour:
  - `in_ready`=0 and the results hold.
  - `pass` = (`err_count`==0) && (`coverage`==4'hF).
  - `start` → RUN, with the same clear as from IDLE.
- `start` is ignored in RUN.
- `in_valid` is ignored outside RUN, and inputs are not accepted or counted there.
- Coverage is sticky; repeated vectors are counted normally.
- `NUM_VECTORS` < 4 can never pass.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, `pass`=0, every counter, `coverage` and the first-fail registers all 0.
- `rst` asserted mid-run aborts the run immediately to the reset values. No partial verdict is retained.
- `in_ready`, `busy` and `done` decode directly from the state register. There is no combinational path from inputs to `in_ready`.
- Latency is 1 cycle: an accept at edge k is reflected in the counters, `coverage` and state at cycle k+1.
- `start` asserted at edge n makes `busy`=1 at n+1. The first accept is possible at edge n+1.
- Back-to-back accepts run at one per cycle, and idle gaps in `in_valid` are allowed.
- `done` and `pass` become valid together, the cycle after the final accept.
- `start` held high continuously in DONE restarts a run every time DONE is entered.

## Structure
- Package `basic_gates_pkg`:
  - bit-index constants AND_B…XNOR_B
  - 7-bit `gates_t` typedef
  - EXP_00/01/10/11 constants
  - state enum {IDLE, RUN, DONE}
- Sub-module `basic_gates_ref`: combinational golden model, `{a,b}` → `gates_t`, using package constants. Reusable by other benches.
- Top contains the FSM, counters, saturation logic and first-fail capture.

## Test plan
- Reset, `start`, vectors 00, 01, 10, 11 with correct `obs` back-to-back → `done` at the 5th cycle after `start`; `pass`=1, `err_count`=0, `coverage`=4'hF, `vec_count`=4.
- Same run, but the vector 10 is sent as `obs`=7'h2B → `err_count`=1, `first_fail_vec`=2, `first_fail_mask`=7'h01, `pass`=0.
- Four correct 00 vectors → `err_count`=0, `coverage`=4'h1, `pass`=0.
- `in_valid` toggled 1/0 each cycle plus `start` pulsed mid-RUN → exactly 4 accepts, no restart, verdict identical to scenario 1.
- `rst` after 2 accepts → next cycle all outputs 0 and IDLE. Then a fresh run passes.
- `CNT_W`=2, `NUM_VECTORS`=3, all three vectors wrong → `err_count`=3. Repeat with `NUM_VECTORS`=3 on an 8-bit build and confirm no wrap. Also restart from DONE via `start` → counters clear on the entry edge.

Source files
------------

// File: rtl/basic_gates_pkg.sv
// Shared constants and types for the basic_gates unit: output bit positions,
// golden response values for each {a,b} combination, and checker FSM states.
package basic_gates_pkg;

   localparam int AND_B   = 6;
   localparam int OR_B    = 5;
   localparam int NOT_A_B = 4;
   localparam int NAND_B  = 3;
   localparam int NOR_B   = 2;
   localparam int XOR_B   = 1;
   localparam int XNOR_B  = 0;

   typedef logic [6:0] gates_t;

   // Bit order {and, or, not_a, nand, nor, xor, xnor}
   localparam gates_t EXP_00 = 7'h1D;
   localparam gates_t EXP_01 = 7'h3A;
   localparam gates_t EXP_10 = 7'h2A;
   localparam gates_t EXP_11 = 7'h61;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/basic_gates_ref.sv
// Combinational golden model of basic_gates: maps the applied {a,b} vector to
// the seven expected gate outputs.
module basic_gates_ref
   import basic_gates_pkg::*;
(
   input  logic   a,
   input  logic   b,
   output gates_t exp_obs
);

   always_comb begin
      exp_obs = EXP_00;
      case ({a, b})
         2'b00:   exp_obs = EXP_00;
         2'b01:   exp_obs = EXP_01;
         2'b10:   exp_obs = EXP_10;
         2'b11:   exp_obs = EXP_11;
         default: exp_obs = EXP_00;
      endcase
   end

endmodule

// File: rtl/basic_gates_checker.sv
// Hardware response monitor for basic_gates: accepts NUM_VECTORS observations,
// compares them against the golden model and issues a done/pass verdict.
module basic_gates_checker
   import basic_gates_pkg::*;
#(
   parameter int NUM_VECTORS = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic             b,
   input  logic [6:0]       obs,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       coverage,
   output logic [CNT_W-1:0] first_fail_vec,
   output logic [6:0]       first_fail_mask,
   output logic [1:0]       state_dbg
);

   state_t state;
   gates_t exp_obs;
   gates_t diff;
   logic   accept;
   logic   last_vec;
   logic   err_sat;

   basic_gates_ref u_ref (
      .a       (a),
      .b       (b),
      .exp_obs (exp_obs)
   );

   // Handshake: an observation transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready depends only on the state register.
   assign in_ready  = (state == RUN);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign state_dbg = state;

   assign accept   = in_valid && in_ready;
   assign diff     = obs ^ exp_obs;
   assign last_vec = (vec_count == CNT_W'(NUM_VECTORS - 1));
   assign err_sat  = &err_count;

   assign pass = done && (err_count == '0) && (coverage == 4'hF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         vec_count       <= '0;
         err_count       <= '0;
         coverage        <= '0;
         first_fail_vec  <= '0;
         first_fail_mask <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= RUN;
                  vec_count       <= '0;
                  err_count       <= '0;
                  coverage        <= '0;
                  first_fail_vec  <= '0;
                  first_fail_mask <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  vec_count         <= vec_count + CNT_W'(1);
                  coverage[{a, b}]  <= 1'b1;
                  if (diff != '0) begin
                     if (!err_sat) err_count <= err_count + CNT_W'(1);
                     // err_count never returns to zero within a run, so zero marks the first miss
                     if (err_count == '0) begin
                        first_fail_vec  <= vec_count;
                        first_fail_mask <= diff;
                     end
                  end
                  if (last_vec) state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_basic_gates_checker.sv
// Directed bench for basic_gates_checker: expected verdicts are queued when a
// run starts and compared by per-instance monitors when done rises.
module tb_basic_gates_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_m = 1'b0;
   logic       start_s = 1'b0;
   logic       in_valid = 1'b0;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic [6:0] obs = '0;

   // Main instance: NUM_VECTORS=4, CNT_W=8
   logic       rdy_m, busy_m, done_m, pass_m;
   logic [7:0] vec_m, err_m, ffv_m;
   logic [3:0] cov_m;
   logic [6:0] ffm_m;
   logic [1:0] st_m;

   // Narrow instance: NUM_VECTORS=3, CNT_W=2
   logic       rdy_s2, busy_s2, done_s2, pass_s2;
   logic [1:0] vec_s2, err_s2, ffv_s2;
   logic [3:0] cov_s2;
   logic [6:0] ffm_s2;
   logic [1:0] st_s2;

   // Wide instance: NUM_VECTORS=3, CNT_W=8
   logic       rdy_s8, busy_s8, done_s8, pass_s8;
   logic [7:0] vec_s8, err_s8, ffv_s8;
   logic [3:0] cov_s8;
   logic [6:0] ffm_s8;
   logic [1:0] st_s8;

   int n_checks = 0;
   int n_pass   = 0;

   logic [35:0] exp_m[$];
   logic [35:0] exp_s2[$];
   logic [35:0] exp_s8[$];

   logic done_m_q  = 1'b0;
   logic done_s2_q = 1'b0;
   logic done_s8_q = 1'b0;

   basic_gates_checker #(.NUM_VECTORS(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start_m), .in_valid(in_valid), .in_ready(rdy_m),
      .a(a), .b(b), .obs(obs), .busy(busy_m), .done(done_m), .pass(pass_m),
      .vec_count(vec_m), .err_count(err_m), .coverage(cov_m),
      .first_fail_vec(ffv_m), .first_fail_mask(ffm_m), .state_dbg(st_m)
   );

   basic_gates_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(rdy_s2),
      .a(a), .b(b), .obs(obs), .busy(busy_s2), .done(done_s2), .pass(pass_s2),
      .vec_count(vec_s2), .err_count(err_s2), .coverage(cov_s2),
      .first_fail_vec(ffv_s2), .first_fail_mask(ffm_s2), .state_dbg(st_s2)
   );

   basic_gates_checker #(.NUM_VECTORS(3), .CNT_W(8)) u_s8 (
      .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(rdy_s8),
      .a(a), .b(b), .obs(obs), .busy(busy_s8), .done(done_s8), .pass(pass_s8),
      .vec_count(vec_s8), .err_count(err_s8), .coverage(cov_s8),
      .first_fail_vec(ffv_s8), .first_fail_mask(ffm_s8), .state_dbg(st_s8)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [35:0] mk(logic p, logic [7:0] v, logic [7:0] e,
                                      logic [3:0] c, logic [7:0] f, logic [6:0] m);
      return {p, v, e, c, f, m};
   endfunction

   function automatic void check_verdict(string tag, logic [35:0] act, logic [35:0] exp);
      check({tag, "_pass"},  8'(act[35]),    8'(exp[35]));
      check({tag, "_vec"},   act[34:27],     exp[34:27]);
      check({tag, "_err"},   act[26:19],     exp[26:19]);
      check({tag, "_cov"},   8'(act[18:15]), 8'(exp[18:15]));
      check({tag, "_ffv"},   act[14:7],      exp[14:7]);
      check({tag, "_ffm"},   8'(act[6:0]),   8'(exp[6:0]));
   endfunction

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      done_m_q <= done_m;
      if (done_m && !done_m_q) begin
         check("m_exp_avail", 8'(exp_m.size() != 0), 8'd1);
         if (exp_m.size() != 0)
            check_verdict("m", mk(pass_m, vec_m, err_m, cov_m, ffv_m, ffm_m), exp_m.pop_front());
      end
   end

   always @(negedge clk) begin
      done_s2_q <= done_s2;
      if (done_s2 && !done_s2_q) begin
         check("s2_exp_avail", 8'(exp_s2.size() != 0), 8'd1);
         if (exp_s2.size() != 0)
            check_verdict("s2", mk(pass_s2, 8'(vec_s2), 8'(err_s2), cov_s2, 8'(ffv_s2), ffm_s2),
                          exp_s2.pop_front());
      end
   end

   always @(negedge clk) begin
      done_s8_q <= done_s8;
      if (done_s8 && !done_s8_q) begin
         check("s8_exp_avail", 8'(exp_s8.size() != 0), 8'd1);
         if (exp_s8.size() != 0)
            check_verdict("s8", mk(pass_s8, vec_s8, err_s8, cov_s8, ffv_s8, ffm_s8), exp_s8.pop_front());
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic do_start_m();
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
   endtask

   task automatic do_start_s();
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
   endtask

   task automatic send(input int inst, input logic va, input logic vb, input logic [6:0] vobs);
      a        = va;
      b        = vb;
      obs      = vobs;
      in_valid = 1'b1;
      if (inst == 0) check("m_in_ready", 8'(rdy_m), 8'd1);
      else           check("s_in_ready", 8'(rdy_s2 & rdy_s8), 8'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_rdy"},  8'(rdy_m),  8'd0);
      check({tag, "_busy"}, 8'(busy_m), 8'd0);
      check({tag, "_done"}, 8'(done_m), 8'd0);
      check({tag, "_pass"}, 8'(pass_m), 8'd0);
      check({tag, "_vec"},  vec_m,      8'd0);
      check({tag, "_err"},  err_m,      8'd0);
      check({tag, "_cov"},  8'(cov_m),  8'd0);
      check({tag, "_ffv"},  ffv_m,      8'd0);
      check({tag, "_ffm"},  8'(ffm_m),  8'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      check("reset_state", 8'(st_m), 8'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: all four vectors correct, back-to-back
      exp_m.push_back(mk(1'b1, 8'd4, 8'd0, 4'hF, 8'd0, 7'h00));
      do_start_m();
      check("s1_busy", 8'(busy_m), 8'd1);
      send(0, 0, 0, 7'h1D);
      send(0, 0, 1, 7'h3A);
      send(0, 1, 0, 7'h2A);
      check("s1_done_early", 8'(done_m), 8'd0);
      send(0, 1, 1, 7'h61);
      check("s1_done", 8'(done_m), 8'd1);
      check("s1_rdy_done", 8'(rdy_m), 8'd0);

      // 2: vector 10 answered with 7'h2B
      exp_m.push_back(mk(1'b0, 8'd4, 8'd1, 4'hF, 8'd2, 7'h01));
      do_start_m();
      send(0, 0, 0, 7'h1D);
      send(0, 0, 1, 7'h3A);
      send(0, 1, 0, 7'h2B);
      send(0, 1, 1, 7'h61);

      // 3: restart from DONE clears; four correct 00 vectors
      exp_m.push_back(mk(1'b0, 8'd4, 8'd0, 4'h1, 8'd0, 7'h00));
      do_start_m();
      check("s3_clr_err", err_m, 8'd0);
      check("s3_clr_ffv", ffv_m, 8'd0);
      check("s3_clr_ffm", 8'(ffm_m), 8'd0);
      check("s3_clr_cov", 8'(cov_m), 8'd0);
      check("s3_clr_vec", vec_m, 8'd0);
      for (int i = 0; i < 4; i++) send(0, 0, 0, 7'h1D);

      // 4: gaps in in_valid and a start pulse mid-run
      exp_m.push_back(mk(1'b1, 8'd4, 8'd0, 4'hF, 8'd0, 7'h00));
      do_start_m();
      send(0, 0, 0, 7'h1D);
      idle();
      start_m = 1'b1;
      send(0, 0, 1, 7'h3A);
      start_m = 1'b0;
      check("s4_no_restart", vec_m, 8'd2);
      idle();
      send(0, 1, 0, 7'h2A);
      idle();
      send(0, 1, 1, 7'h61);
      check("s4_done", 8'(done_m), 8'd1);
      in_valid = 1'b1; a = 1'b0; b = 1'b0; obs = 7'h00;
      @(negedge clk);
      in_valid = 1'b0;
      check("s4_ignored_vec", vec_m, 8'd4);
      check("s4_ignored_err", err_m, 8'd0);

      // 5: reset after two accepts aborts, then a fresh run passes
      do_start_m();
      send(0, 0, 0, 7'h1D);
      send(0, 0, 1, 7'h3A);
      rst = 1'b1;
      #1;
      check_zero("s5_abort");
      @(negedge clk);
      check("s5_state", 8'(st_m), 8'd0);
      rst = 1'b0;
      @(negedge clk);
      exp_m.push_back(mk(1'b1, 8'd4, 8'd0, 4'hF, 8'd0, 7'h00));
      do_start_m();
      send(0, 1, 1, 7'h61);
      send(0, 1, 0, 7'h2A);
      send(0, 0, 1, 7'h3A);
      send(0, 0, 0, 7'h1D);

      // 6: three-vector builds, all wrong, then restart from DONE
      exp_s2.push_back(mk(1'b0, 8'd3, 8'd3, 4'hB, 8'd0, 7'h1D));
      exp_s8.push_back(mk(1'b0, 8'd3, 8'd3, 4'hB, 8'd0, 7'h1D));
      do_start_s();
      send(1, 0, 0, 7'h00);
      send(1, 0, 1, 7'h00);
      send(1, 1, 1, 7'h00);
      check("s6_done_s2", 8'(done_s2), 8'd1);
      check("s6_err_s2", 8'(err_s2), 8'd3);
      check("s6_err_s8", err_s8, 8'd3);
      exp_s2.push_back(mk(1'b0, 8'd3, 8'd0, 4'h7, 8'd0, 7'h00));
      exp_s8.push_back(mk(1'b0, 8'd3, 8'd0, 4'h7, 8'd0, 7'h00));
      do_start_s();
      check("s6_clr_vec_s2", 8'(vec_s2), 8'd0);
      check("s6_clr_err_s2", 8'(err_s2), 8'd0);
      check("s6_clr_ffm_s8", 8'(ffm_s8), 8'd0);
      send(1, 0, 0, 7'h1D);
      send(1, 0, 1, 7'h3A);
      send(1, 1, 0, 7'h2A);

      // 7: start held high through DONE restarts immediately
      exp_m.push_back(mk(1'b1, 8'd4, 8'd0, 4'hF, 8'd0, 7'h00));
      start_m = 1'b1;
      @(negedge clk);
      send(0, 0, 0, 7'h1D);
      send(0, 0, 1, 7'h3A);
      send(0, 1, 0, 7'h2A);
      send(0, 1, 1, 7'h61);
      check("s7_done", 8'(done_m), 8'd1);
      exp_m.push_back(mk(1'b0, 8'd4, 8'd0, 4'h1, 8'd0, 7'h00));
      @(negedge clk);
      start_m = 1'b0;
      check("s7_rerun_busy", 8'(busy_m), 8'd1);
      check("s7_rerun_vec", vec_m, 8'd0);
      for (int i = 0; i < 4; i++) send(0, 0, 0, 7'h1D);

      repeat (3) @(negedge clk);
      check("m_queue_drained",  8'(exp_m.size()),  8'd0);
      check("s2_queue_drained", 8'(exp_s2.size()), 8'd0);
      check("s8_queue_drained", 8'(exp_s8.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
